// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/operand/grant and result handshake bundle for shift_arbiter.
interface shift_arbiter_if;
    logic        req_0;
    logic        req_1;
    logic [31:0] in_0;
    logic [31:0] in_1;
    logic [4:0]  shift_0;
    logic [4:0]  shift_1;
    logic        select_0;
    logic        select_1;
    logic        gnt_0;
    logic        gnt_1;
    logic [31:0] out;
    logic        out_valid;
    logic        out_tag;
    logic        out_ack;
    logic        busy;
    modport master (
        output req_0, req_1, in_0, in_1, shift_0, shift_1, select_0, select_1, out_ack,
        input  gnt_0, gnt_1, out, out_valid, out_tag, busy
    );
    modport slave (
        input  req_0, req_1, in_0, in_1, shift_0, shift_1, select_0, select_1, out_ack,
        output gnt_0, gnt_1, out, out_valid, out_tag, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit shifter; IDLE -> SHIFT -> DONE.
// Define SHIFT_ARB_RR_EN for round-robin arbitration, otherwise requester 0 has priority.
module shift_arbiter (
    input logic            clk,
    input logic            reset,
    shift_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state;
    logic [31:0] op_in;
    logic [4:0]  op_shift;
    logic        op_sel;
    logic        op_tag;
    logic        any_req;
    logic        win;
    logic        grant;
`ifdef SHIFT_ARB_RR_EN
    logic        last;
    assign win = (bus.req_0 && bus.req_1) ? ~last : bus.req_1;
`else
    assign win = ~bus.req_0;
`endif
    assign any_req   = bus.req_0 | bus.req_1;
    // Grant is decided and operands captured in the same IDLE cycle.
    assign grant     = (state == IDLE) && any_req && !reset;
    assign bus.gnt_0 = grant && !win;
    assign bus.gnt_1 = grant && win;
    assign bus.busy  = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_in         <= '0;
            op_shift      <= '0;
            op_sel        <= 1'b0;
            op_tag        <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_tag   <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
            last          <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    op_in    <= win ? bus.in_1 : bus.in_0;
                    op_shift <= win ? bus.shift_1 : bus.shift_0;
                    op_sel   <= win ? bus.select_1 : bus.select_0;
                    op_tag   <= win;
`ifdef SHIFT_ARB_RR_EN
                    last     <= win;
`endif
                    state    <= SHIFT;
                end
                SHIFT: begin
                    bus.out       <= op_sel ? op_in >> op_shift : op_in << op_shift;
                    bus.out_valid <= 1'b1;
                    bus.out_tag   <= op_tag;
                    state         <= DONE;
                end
                DONE: if (bus.out_ack) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed self-checking bench for shift_arbiter (fixed and round-robin builds).
module tb_shift_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    shift_arbiter_if bus ();
    shift_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    // Runs one operation from the IDLE cycle where the requests are presented.
    task automatic do_op(input string tag, input logic r0, input logic r1, input logic hold,
                         input logic e_g0, input logic e_g1, input logic [31:0] e_out, input logic e_tag);
        bus.req_0 = r0;
        bus.req_1 = r1;
        #1;
        chk({tag, " gnt_0"}, bus.gnt_0, e_g0);
        chk({tag, " gnt_1"}, bus.gnt_1, e_g1);
        tick();
        if (!hold) begin
            bus.req_0 = 1'b0;
            bus.req_1 = 1'b0;
        end
        #1;
        chk({tag, " shift busy"}, bus.busy, 1'b1);
        chk({tag, " shift gnt"}, bus.gnt_0 | bus.gnt_1, 1'b0);
        chk({tag, " shift valid"}, bus.out_valid, 1'b0);
        tick();
        chk({tag, " valid"}, bus.out_valid, 1'b1);
        chk({tag, " out"}, bus.out, e_out);
        chk({tag, " tag"}, bus.out_tag, e_tag);
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        chk({tag, " ack valid"}, bus.out_valid, 1'b0);
        chk({tag, " ack busy"}, bus.busy, 1'b0);
    endtask
    initial begin
        bus.req_0 = 0; bus.req_1 = 0; bus.out_ack = 0;
        bus.in_0 = 0; bus.in_1 = 0; bus.shift_0 = 0; bus.shift_1 = 0;
        bus.select_0 = 0; bus.select_1 = 0;
        tick();
        tick();
        chk("rst busy", bus.busy, 1'b0);
        chk("rst valid", bus.out_valid, 1'b0);
        chk("rst out", bus.out, 32'h0);
        chk("rst tag", bus.out_tag, 1'b0);
        bus.req_0 = 1; bus.in_0 = 456; bus.shift_0 = 7; bus.select_0 = 0;
        #1;
        chk("rst gnt_0 gated", bus.gnt_0, 1'b0);
        reset = 0;
        #1;
        chk("s1 gnt_0", bus.gnt_0, 1'b1);
        chk("s1 gnt_1", bus.gnt_1, 1'b0);
        tick();
        bus.req_0 = 0;
        #1;
        chk("s1 shift busy", bus.busy, 1'b1);
        chk("s1 shift gnt_0", bus.gnt_0, 1'b0);
        tick();
        chk("s1 valid", bus.out_valid, 1'b1);
        chk("s1 out", bus.out, 32'd58368);
        chk("s1 tag", bus.out_tag, 1'b0);
        bus.req_1 = 1; bus.in_1 = 32'h80000000; bus.shift_1 = 31; bus.select_1 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold out", bus.out, 32'd58368);
            chk("hold valid", bus.out_valid, 1'b1);
            chk("hold tag", bus.out_tag, 1'b0);
            chk("hold gnt_1", bus.gnt_1, 1'b0);
            chk("hold busy", bus.busy, 1'b1);
        end
        bus.out_ack = 1;
        tick();
        bus.out_ack = 0;
        chk("s1 ack valid", bus.out_valid, 1'b0);
        chk("s1 ack busy", bus.busy, 1'b0);
        chk("s2 gnt_1", bus.gnt_1, 1'b1);
        chk("s2 gnt_0", bus.gnt_0, 1'b0);
        tick();
        bus.req_1 = 0;
        bus.out_ack = 1;
        tick();
        bus.out_ack = 0;
        tick();
        chk("ack in shift ignored", bus.out_valid, 1'b1);
        chk("s2 out", bus.out, 32'h1);
        chk("s2 tag", bus.out_tag, 1'b1);
        bus.out_ack = 1;
        tick();
        bus.out_ack = 0;
        chk("s2 ack valid", bus.out_valid, 1'b0);
        bus.in_0 = 32'hDEADBEEF; bus.shift_0 = 0; bus.select_0 = 1;
        do_op("shift0", 1, 0, 0, 1, 0, 32'hDEADBEEF, 0);
        bus.in_0 = 32'hFFFFFFFF; bus.shift_0 = 31; bus.select_0 = 0;
        do_op("shl31", 1, 0, 0, 1, 0, 32'h80000000, 0);
        bus.in_1 = 5; bus.shift_1 = 2; bus.select_1 = 0;
        bus.req_1 = 1;
        #1;
        chk("r gnt_1", bus.gnt_1, 1'b1);
        tick();
        bus.req_1 = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("r busy", bus.busy, 1'b0);
        chk("r valid", bus.out_valid, 1'b0);
        chk("r out", bus.out, 32'h0);
        tick();
        tick();
        chk("r no result", bus.out_valid, 1'b0);
        do_op("after rst", 0, 1, 0, 0, 1, 32'd20, 1);
        bus.in_0 = 1; bus.shift_0 = 1; bus.select_0 = 0;
        bus.in_1 = 8; bus.shift_1 = 1; bus.select_1 = 1;
`ifdef SHIFT_ARB_RR_EN
        do_op("rr0", 1, 1, 1, 1, 0, 32'd2, 0);
        do_op("rr1", 1, 1, 1, 0, 1, 32'd4, 1);
        do_op("rr2", 1, 1, 1, 1, 0, 32'd2, 0);
        do_op("rr3", 1, 1, 1, 0, 1, 32'd4, 1);
`else
        do_op("fx0", 1, 1, 1, 1, 0, 32'd2, 0);
        do_op("fx1", 1, 1, 1, 1, 0, 32'd2, 0);
        do_op("fx2", 1, 1, 1, 1, 0, 32'd2, 0);
        do_op("fx3", 1, 1, 1, 1, 0, 32'd2, 0);
`endif
        bus.req_0 = 0;
        bus.req_1 = 0;
        tick();
        chk("idle gnt", bus.gnt_0 | bus.gnt_1, 1'b0);
        chk("idle busy", bus.busy, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
